// File: rtl/morra_cinese_param.sv
// rtl/morra_cinese_param.sv - parametrised rock-paper-scissors match controller
module morra_cinese_param #(
  parameter int CFG_W      = 4,
  parameter int MANCHE_MIN = 4,
  parameter int LEAD       = 2,
  parameter int NOREPEAT   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             Inizia,
  input  logic [CFG_W-1:0] Config,
  input  logic [1:0]       Primo,
  input  logic [1:0]       Secondo,
  output logic [1:0]       Manche,
  output logic [1:0]       Partita
);

  // Largest round budget; counters and scores are sized so it never wraps.
  localparam int MAX_VAL = MANCHE_MIN + (1 << CFG_W) - 1;
  localparam int CNT_W   = $clog2(MAX_VAL + 1);
  localparam logic [CNT_W-1:0] MIN_C = CNT_W'(MANCHE_MIN);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PLAY = 2'd1,
    S_END  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       manche_q, manche_d;
  logic [1:0]       partita_q, partita_d;
  logic [CNT_W-1:0] max_q, max_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] s1_q, s1_d;
  logic [CNT_W-1:0] s2_q, s2_d;
  // No-repeat memory: valid flag, winner (0 = Primo, 1 = Secondo), winning move.
  logic             nr_valid_q, nr_valid_d;
  logic             nr_who_q, nr_who_d;
  logic [1:0]       nr_move_q, nr_move_d;

  logic             moves_ok;
  logic             p1_beats;
  logic             p2_beats;
  logic             repeat_hit;
  logic             round_ok;
  logic             end_hit;
  logic [CNT_W-1:0] cnt_inc;
  logic [CNT_W-1:0] s1_inc;
  logic [CNT_W-1:0] s2_inc;
  logic [CNT_W-1:0] lead_v;

  // Evaluate the current round and the post-update end condition.
  always_comb begin
    moves_ok = (Primo != 2'b00) && (Secondo != 2'b00);
    p1_beats = (Primo == 2'b01 && Secondo == 2'b11) ||
               (Primo == 2'b11 && Secondo == 2'b10) ||
               (Primo == 2'b10 && Secondo == 2'b01);
    p2_beats = (Secondo == 2'b01 && Primo == 2'b11) ||
               (Secondo == 2'b11 && Primo == 2'b10) ||
               (Secondo == 2'b10 && Primo == 2'b01);
    repeat_hit = 1'b0;
    if (NOREPEAT != 0 && nr_valid_q) begin
      repeat_hit = nr_who_q ? (Secondo == nr_move_q) : (Primo == nr_move_q);
    end
    round_ok = (state_q == S_PLAY) && moves_ok && !repeat_hit;
    cnt_inc  = count_q + CNT_W'(1);
    s1_inc   = s1_q + CNT_W'(p1_beats);
    s2_inc   = s2_q + CNT_W'(p2_beats);
    lead_v   = (s1_inc >= s2_inc) ? (s1_inc - s2_inc) : (s2_inc - s1_inc);
    end_hit  = round_ok &&
               ((cnt_inc == max_q) ||
                ((32'(cnt_inc) >= 32'(MANCHE_MIN)) && (32'(lead_v) >= 32'(LEAD))));
  end

  // Next-state logic; Inizia restarts the match from any state.
  always_comb begin
    state_d = state_q;
    if (Inizia) begin
      state_d = S_PLAY;
    end else begin
      case (state_q)
        S_PLAY:  if (end_hit) state_d = S_END;
        default: state_d = state_q;
      endcase
    end
  end

  // Output and datapath next values: scores, round count, memory, results.
  always_comb begin
    manche_d   = 2'b00;
    partita_d  = partita_q;
    max_d      = max_q;
    count_d    = count_q;
    s1_d       = s1_q;
    s2_d       = s2_q;
    nr_valid_d = nr_valid_q;
    nr_who_d   = nr_who_q;
    nr_move_d  = nr_move_q;
    if (Inizia) begin
      max_d      = MIN_C + CNT_W'(Config);
      count_d    = '0;
      s1_d       = '0;
      s2_d       = '0;
      nr_valid_d = 1'b0;
      nr_who_d   = 1'b0;
      nr_move_d  = 2'b00;
      partita_d  = 2'b00;
    end else if (round_ok) begin
      count_d = cnt_inc;
      s1_d    = s1_inc;
      s2_d    = s2_inc;
      if (p1_beats) begin
        manche_d   = 2'b01;
        nr_valid_d = 1'b1;
        nr_who_d   = 1'b0;
        nr_move_d  = Primo;
      end else if (p2_beats) begin
        manche_d   = 2'b10;
        nr_valid_d = 1'b1;
        nr_who_d   = 1'b1;
        nr_move_d  = Secondo;
      end else begin
        manche_d   = 2'b11;
        nr_valid_d = 1'b0;
      end
      if (end_hit) begin
        if (s1_inc > s2_inc)      partita_d = 2'b01;
        else if (s2_inc > s1_inc) partita_d = 2'b10;
        else                      partita_d = 2'b11;
      end
    end
  end

  // State and datapath registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      manche_q   <= 2'b00;
      partita_q  <= 2'b00;
      max_q      <= '0;
      count_q    <= '0;
      s1_q       <= '0;
      s2_q       <= '0;
      nr_valid_q <= 1'b0;
      nr_who_q   <= 1'b0;
      nr_move_q  <= 2'b00;
    end else begin
      state_q    <= state_d;
      manche_q   <= manche_d;
      partita_q  <= partita_d;
      max_q      <= max_d;
      count_q    <= count_d;
      s1_q       <= s1_d;
      s2_q       <= s2_d;
      nr_valid_q <= nr_valid_d;
      nr_who_q   <= nr_who_d;
      nr_move_q  <= nr_move_d;
    end
  end

  assign Manche  = manche_q;
  assign Partita = partita_q;

endmodule
